paddle_ctrl: RTL

//  Parametrised Pong paddle controller: one instance per side, between the keyboard decoder and the

---
 rtl/paddle_ctrl_if.sv | 36 +++
 rtl/paddle_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/paddle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : paddle_ctrl_if
// Description : Bundle of paddle controller inputs (tick, side, mode, keys,
//               ball_y) and outputs (pos_x, pos_y, speed, edge flags).
//               master : drives the inputs and observes the outputs
//               slave  : the paddle controller itself
// Revision    : 1.0 - initial release
// ============================================================================
interface paddle_ctrl_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic           tick;
    logic           side;
    logic           mode;
    logic           key_up;
    logic           key_down;
    logic [Y_W-1:0] ball_y;
    logic [X_W-1:0] pos_x;
    logic [Y_W-1:0] pos_y;
    logic [2:0]     speed;
    logic           at_top;
    logic           at_bottom;

    modport master (
        output tick, side, mode, key_up, key_down, ball_y,
        input  pos_x, pos_y, speed, at_top, at_bottom
    );

    modport slave (
        input  tick, side, mode, key_up, key_down, ball_y,
        output pos_x, pos_y, speed, at_top, at_bottom
    );
endinterface
`default_nettype wire

// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : paddle_ctrl
// Description : Pong paddle controller. Once per movement tick it moves the
//               paddle under human keys or an AI ball tracker, accelerates
//               while one direction is held, clamps to the playfield and
//               flags edge contact.
// Ports       : clk, rst (sync, active-high)
//               bus.tick/side/mode/key_up/key_down/ball_y  (inputs)
//               bus.pos_x/pos_y/speed/at_top/at_bottom      (outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module paddle_ctrl #(
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int SCREEN_H    = 480,
    parameter int PAD_H       = 56,
    parameter int LEFT_X      = 0,
    parameter int RIGHT_X     = 614,
    parameter int RESET_Y     = 212,
    parameter int MAX_SPEED   = 4,
    parameter int AI_SPEED    = 3,
    parameter int ACCEL_TICKS = 8,
    parameter int DEADZONE    = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    paddle_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(ACCEL_TICKS + 1);

    localparam logic [Y_W:0]   c_MAX_Y   = (Y_W+1)'(SCREEN_H - PAD_H);
    localparam logic [Y_W:0]   c_HALF    = (Y_W+1)'(PAD_H / 2);
    localparam logic [Y_W:0]   c_DZ      = (Y_W+1)'(DEADZONE);
    localparam logic [Y_W-1:0] c_RESET_Y = Y_W'(RESET_Y);
    localparam logic [CNT_W-1:0] c_ACCEL = CNT_W'(ACCEL_TICKS);

    // The request encoding reuses the state encoding: NONE == IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DN   = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt, w_req;
    logic [Y_W-1:0]   r_pos_y, w_pos_nxt;
    logic [2:0]       r_speed, w_spd_nxt, w_cap;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [Y_W:0]     w_centre, w_ball, w_pos_ext, w_step, w_sum;

    // Direction request; all compares are one bit wider so nothing wraps.
    always_comb begin
        w_req    = S_IDLE;
        w_centre = {1'b0, r_pos_y} + c_HALF;
        w_ball   = {1'b0, bus.ball_y};
        if (bus.mode) begin
            if (w_ball + c_DZ < w_centre)
                w_req = S_UP;
            else if (w_ball > w_centre + c_DZ)
                w_req = S_DN;
        end else begin
            if (bus.key_up && !bus.key_down)
                w_req = S_UP;
            else if (bus.key_down && !bus.key_up)
                w_req = S_DN;
        end
    end

    assign w_cap = bus.mode ? 3'(AI_SPEED) : 3'(MAX_SPEED);

    always_comb begin
        w_state_nxt = r_state;
        w_spd_nxt   = r_speed;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = r_pos_y;
        w_pos_ext   = {1'b0, r_pos_y};
        w_step      = '0;
        w_sum       = '0;
        if (bus.tick) begin
            if (w_req == S_IDLE) begin
                w_state_nxt = S_IDLE;
                w_spd_nxt   = 3'd0;
                w_cnt_nxt   = '0;
            end else begin
                if (w_req != r_state) begin
                    w_state_nxt = w_req;
                    w_spd_nxt   = 3'd1;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    if (r_cnt == c_ACCEL && r_speed < w_cap) begin
                        w_spd_nxt = r_speed + 3'd1;
                        w_cnt_nxt = CNT_W'(1);
                    end else if (r_cnt != c_ACCEL) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    // A switch into AI mode can leave speed above the new cap.
                    if (w_spd_nxt > w_cap)
                        w_spd_nxt = w_cap;
                end
                // Move by the updated speed on this same tick.
                w_step = (Y_W+1)'(w_spd_nxt);
                w_sum  = w_pos_ext + w_step;
                if (w_req == S_UP)
                    w_pos_nxt = (w_pos_ext < w_step) ? '0 : Y_W'(w_pos_ext - w_step);
                else
                    w_pos_nxt = (w_sum > c_MAX_Y) ? Y_W'(c_MAX_Y) : Y_W'(w_sum);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pos_y <= c_RESET_Y;
            r_speed <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pos_y <= w_pos_nxt;
            r_speed <= w_spd_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.pos_x     = bus.side ? X_W'(RIGHT_X) : X_W'(LEFT_X);
    assign bus.pos_y     = r_pos_y;
    assign bus.speed     = r_speed;
    assign bus.at_top    = (r_pos_y == '0);
    assign bus.at_bottom = ({1'b0, r_pos_y} == c_MAX_Y);
endmodule
`default_nettype wire
